// File: rtl/cdb_broadcaster.sv
// Common-data-bus writeback: per-source in-order result queues, round-robin grant of up
// to BROADCAST_PORTS heads per cycle onto registered lanes, with branch-mask squash on flush.
module cdb_broadcaster #(
    parameter int SOURCES         = 4,
    parameter int BROADCAST_PORTS = 4,
    parameter int ROB_DEPTH       = 16,
    parameter int OPERAND_WIDTH   = 32,
    parameter int FIFO_DEPTH      = 2,
    parameter int BRANCH_DEPTH    = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [SOURCES-1:0]                                   src_valid,
    output logic [SOURCES-1:0]                                   src_ready,
    input  logic [SOURCES-1:0][$clog2(ROB_DEPTH)-1:0]            src_tag,
    input  logic [SOURCES-1:0][OPERAND_WIDTH-1:0]                src_data,
    input  logic [SOURCES-1:0][BRANCH_DEPTH-1:0]                 src_branch_if,
    output logic [BROADCAST_PORTS-1:0]                           cdb_valid,
    output logic [BROADCAST_PORTS-1:0][$clog2(ROB_DEPTH)-1:0]    cdb_tag,
    output logic [BROADCAST_PORTS-1:0][OPERAND_WIDTH-1:0]        cdb_data,
    input  logic                                                 branch_resolved,
    input  logic                                                 flush
);
    // Handshake: a result transfers on a rising clk edge where src_valid & src_ready;
    // src_ready comes from registered occupancy only. cdb lanes are valid for one cycle.
    localparam int TW = $clog2(ROB_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic [TW-1:0]            q_tag    [SOURCES][FIFO_DEPTH];
    logic [OPERAND_WIDTH-1:0] q_data   [SOURCES][FIFO_DEPTH];
    logic [BRANCH_DEPTH-1:0]  q_mask   [SOURCES][FIFO_DEPTH];
    logic [CW-1:0]            cnt      [SOURCES];
    logic [TW-1:0]            n_q_tag  [SOURCES][FIFO_DEPTH];
    logic [OPERAND_WIDTH-1:0] n_q_data [SOURCES][FIFO_DEPTH];
    logic [BRANCH_DEPTH-1:0]  n_q_mask [SOURCES][FIFO_DEPTH];
    logic [CW-1:0]            n_cnt    [SOURCES];
    logic [PW-1:0]            rr_ptr, n_rr_ptr;

    logic [SOURCES-1:0]         grant;
    logic [BROADCAST_PORTS-1:0] lane_on;
    logic [PW-1:0]              lane_src [BROADCAST_PORTS];

    logic [BROADCAST_PORTS-1:0]                    n_cdb_valid;
    logic [BROADCAST_PORTS-1:0][TW-1:0]            n_cdb_tag;
    logic [BROADCAST_PORTS-1:0][OPERAND_WIDTH-1:0] n_cdb_data;

    always_comb begin
        for (int i = 0; i < SOURCES; i++) begin
            src_ready[i] = (int'(cnt[i]) < FIFO_DEPTH);
        end
    end

    // Scan non-empty heads from rr_ptr; the n-th hit lands on lane n.
    always_comb begin
        int n;
        int idx;
        n        = 0;
        idx      = 0;
        grant    = '0;
        lane_on  = '0;
        n_rr_ptr = rr_ptr;
        for (int k = 0; k < BROADCAST_PORTS; k++) begin
            lane_src[k] = '0;
        end
        for (int k = 0; k < SOURCES; k++) begin
            idx = (int'(rr_ptr) + k) % SOURCES;
            if (cnt[idx] != '0 && n < BROADCAST_PORTS) begin
                grant[idx]  = 1'b1;
                lane_on[n]  = 1'b1;
                lane_src[n] = PW'(idx);
                n_rr_ptr    = PW'((idx + 1) % SOURCES);
                n++;
            end
        end
    end

    // A grant whose mask is on the flushed path still pops but broadcasts nothing.
    always_comb begin
        n_cdb_valid = '0;
        n_cdb_tag   = '0;
        n_cdb_data  = '0;
        for (int k = 0; k < BROADCAST_PORTS; k++) begin
            if (lane_on[k] && !(flush && q_mask[lane_src[k]][0] != '0)) begin
                n_cdb_valid[k] = 1'b1;
                n_cdb_tag[k]   = q_tag[lane_src[k]][0];
                n_cdb_data[k]  = q_data[lane_src[k]][0];
            end
        end
    end

    // Rebuild each queue: drop the popped head and squashed entries, compact, then append.
    always_comb begin
        int w;
        logic [BRANCH_DEPTH-1:0] m;
        w = 0;
        m = '0;
        for (int i = 0; i < SOURCES; i++) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                n_q_tag[i][j]  = '0;
                n_q_data[i][j] = '0;
                n_q_mask[i][j] = '0;
            end
            w = 0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                if (j < int'(cnt[i]) && !(j == 0 && grant[i]) &&
                    !(flush && q_mask[i][j] != '0)) begin
                    m = (branch_resolved && !flush) ? (q_mask[i][j] >> 1) : q_mask[i][j];
                    n_q_tag[i][w]  = q_tag[i][j];
                    n_q_data[i][w] = q_data[i][j];
                    n_q_mask[i][w] = m;
                    w++;
                end
            end
            if (src_valid[i] && src_ready[i] && !(flush && src_branch_if[i] != '0)) begin
                m = (branch_resolved && !flush) ? (src_branch_if[i] >> 1) : src_branch_if[i];
                n_q_tag[i][w]  = src_tag[i];
                n_q_data[i][w] = src_data[i];
                n_q_mask[i][w] = m;
                w++;
            end
            n_cnt[i] = CW'(w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            for (int i = 0; i < SOURCES; i++) begin
                cnt[i] <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    q_tag[i][j]  <= '0;
                    q_data[i][j] <= '0;
                    q_mask[i][j] <= '0;
                end
            end
        end else begin
            rr_ptr    <= n_rr_ptr;
            cdb_valid <= n_cdb_valid;
            cdb_tag   <= n_cdb_tag;
            cdb_data  <= n_cdb_data;
            cnt       <= n_cnt;
            q_tag     <= n_q_tag;
            q_data    <= n_q_data;
            q_mask    <= n_q_mask;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster with two lanes, so arbitration is exercised: a queue-based
// reference model predicts each cycle's lanes and src_ready; a monitor compares them.
module tb_cdb_broadcaster;
    localparam int SRC = 4;
    localparam int BP  = 2;
    localparam int RD  = 16;
    localparam int OW  = 32;
    localparam int FD  = 2;
    localparam int BD  = 4;
    localparam int TW  = $clog2(RD);
    localparam int LW  = 1 + TW + OW;
    localparam int W   = BP * LW;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [SRC-1:0]                src_valid;
    logic [SRC-1:0]                src_ready;
    logic [SRC-1:0][TW-1:0]        src_tag;
    logic [SRC-1:0][OW-1:0]        src_data;
    logic [SRC-1:0][BD-1:0]        src_branch_if;
    logic [BP-1:0]                 cdb_valid;
    logic [BP-1:0][TW-1:0]         cdb_tag;
    logic [BP-1:0][OW-1:0]         cdb_data;
    logic                          branch_resolved;
    logic                          flush;

    cdb_broadcaster #(
        .SOURCES(SRC), .BROADCAST_PORTS(BP), .ROB_DEPTH(RD),
        .OPERAND_WIDTH(OW), .FIFO_DEPTH(FD), .BRANCH_DEPTH(BD)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_tag(src_tag),
        .src_data(src_data), .src_branch_if(src_branch_if),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .branch_resolved(branch_resolved), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [OW-1:0] data;
        logic [BD-1:0] mask;
    } ent_t;

    ent_t         mq[SRC][$];
    int           rr_m = 0;
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    // One clock of the reference behaviour; result is what the lanes show after this edge.
    task automatic model_step();
        logic [W-1:0]   e_l;
        logic [SRC-1:0] rdy;
        ent_t           e;
        int             n;
        int             last;
        int             s;
        e_l  = '0;
        n    = 0;
        last = -1;
        for (int i = 0; i < SRC; i++) rdy[i] = (mq[i].size() < FD);
        for (int k = 0; k < SRC; k++) begin
            s = (rr_m + k) % SRC;
            if (mq[s].size() != 0 && n < BP) begin
                e = mq[s].pop_front();
                if (!(flush && e.mask != '0)) e_l[n*LW +: LW] = {1'b1, e.tag, e.data};
                n++;
                last = s;
            end
        end
        if (flush) begin
            for (int i = 0; i < SRC; i++) begin
                for (int j = mq[i].size() - 1; j >= 0; j--) begin
                    if (mq[i][j].mask != '0) mq[i].delete(j);
                end
            end
        end
        for (int i = 0; i < SRC; i++) begin
            if (src_valid[i] && rdy[i] && !(flush && src_branch_if[i] != '0)) begin
                e.tag  = src_tag[i];
                e.data = src_data[i];
                e.mask = src_branch_if[i];
                mq[i].push_back(e);
            end
        end
        if (branch_resolved && !flush) begin
            for (int i = 0; i < SRC; i++) begin
                for (int j = 0; j < mq[i].size(); j++) begin
                    e = mq[i][j];
                    e.mask = e.mask >> 1;
                    mq[i][j] = e;
                end
            end
        end
        if (last >= 0) rr_m = (last + 1) % SRC;
        exp_q.push_back(e_l);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < SRC; i++) mq[i].delete();
            rr_m = 0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            model_step();
        end
    end

    // Monitor: outputs only change on clk or rst, so the falling edge is a quiet sample point.
    initial forever begin
        logic [W-1:0]   act;
        logic [W-1:0]   exp_l;
        logic [SRC-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < BP; k++) act[k*LW +: LW] = {cdb_valid[k], cdb_tag[k], cdb_data[k]};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL lanes_underflow cyc=%0d got=%h required=<queued expectation>", cyc, act);
        end else begin
            exp_l = exp_q.pop_front();
            if (act !== exp_l) begin
                failures++;
                $display("FAIL lanes cyc=%0d got=%h required=%h", cyc, act, exp_l);
            end
        end
        for (int i = 0; i < SRC; i++) exp_rdy[i] = (mq[i].size() < FD);
        checks++;
        if (src_ready !== exp_rdy) begin
            failures++;
            $display("FAIL src_ready cyc=%0d got=%b required=%b", cyc, src_ready, exp_rdy);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        src_valid       = '0;
        src_tag         = '0;
        src_data        = '0;
        src_branch_if   = '0;
        branch_resolved = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic offer(input int s, input logic [TW-1:0] t, input logic [OW-1:0] d,
                         input logic [BD-1:0] m);
        src_valid[s]     = 1'b1;
        src_tag[s]       = t;
        src_data[s]      = d;
        src_branch_if[s] = m;
    endtask

    task automatic random_inputs();
        clear_inputs();
        for (int s = 0; s < SRC; s++) begin
            if ($urandom_range(0, 3) != 0)
                offer(s, TW'($urandom), $urandom,
                      ($urandom_range(0, 3) == 0) ? BD'($urandom) : '0);
        end
        branch_resolved = ($urandom_range(0, 5) == 0);
        flush           = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Lone result on source 0.
        step(); offer(0, 4'd5, 32'hDEAD_BEEF, 4'b0000);
        step(); clear_inputs();
        repeat (3) step();

        // All sources at once: two lanes drain them over two cycles.
        step();
        for (int s = 0; s < SRC; s++) offer(s, TW'(s + 8), 32'hA000_0000 + s, 4'b0000);
        step(); clear_inputs();
        repeat (4) step();

        // Clean then speculative result on src1, flushed alongside a speculative src2 push.
        step(); offer(1, 4'd1, 32'h1111_0000, 4'b0000);
        step(); clear_inputs(); offer(1, 4'd2, 32'h1111_0001, 4'b0001);
        step(); clear_inputs(); offer(2, 4'd3, 32'h2222_0010, 4'b0010); flush = 1'b1;
        step(); clear_inputs();
        repeat (3) step();

        // Mask aging ahead of a flush while lanes are contended.
        step();
        for (int s = 0; s < SRC; s++) offer(s, TW'(s), 32'hB000_0000 + s, (s == 3) ? 4'b0001 : 4'b0000);
        offer(2, 4'd7, 32'hB000_0007, 4'b0010);
        branch_resolved = 1'b1;
        step(); clear_inputs(); branch_resolved = 1'b1;
        step(); clear_inputs(); flush = 1'b1;
        step(); clear_inputs();
        repeat (4) step();

        // Saturated sources, then a reset pulse mid-stream.
        for (int c = 0; c < 6; c++) begin
            step();
            for (int s = 0; s < SRC; s++) offer(s, TW'($urandom), $urandom, 4'b0000);
        end
        step(); rst = 1'b1;
        step(); rst = 1'b0; clear_inputs();
        repeat (3) step();

        for (int c = 0; c < 600; c++) begin
            step();
            random_inputs();
        end

        step(); clear_inputs();
        repeat (8) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
